// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: one request in flight, fixed WAIT_CYCLES
// latency, word-addressed RAM with misaligned/out-of-range error responses.
module data_mem_responder #(
  parameter int ADDR_BITS   = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int         DEPTH    = 2 ** ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   req_ready_q, req_ready_d;

  logic                   enter_resp_s;
  logic                   op_we_s;
  logic [31:0]            op_addr_s;
  logic [31:0]            op_wdata_s;
  logic                   op_err_s;
  logic [ADDR_BITS-1:0]   op_idx_s;
  logic                   mem_wen_s;

  logic [31:0]            mem_q [DEPTH];

  function automatic logic addr_err(input logic [31:0] a);
    addr_err = (a[1:0] != 2'b00) || ((a >> (ADDR_BITS + 2)) != 32'd0);
  endfunction

  // With WAIT_CYCLES=0 RESP is entered on the acceptance edge, before the
  // capture registers hold the request, so the live inputs are used there.
  always_comb begin
    if (state_q == IDLE) begin
      op_we_s    = memWrite;
      op_addr_s  = addr;
      op_wdata_s = wdata;
    end else begin
      op_we_s    = we_q;
      op_addr_s  = addr_q;
      op_wdata_s = wdata_q;
    end
    op_err_s = addr_err(op_addr_s);
    op_idx_s = op_addr_s[ADDR_BITS+1:2];
  end

  // Next-state, counter and request-capture logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    enter_resp_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = memWrite;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d      = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response payload and handshake outputs, loaded on the edge entering RESP.
  always_comb begin
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = (state_d == RESP);
    req_ready_d = (state_d == IDLE);
    if (enter_resp_s) begin
      err_d   = op_err_s;
      rdata_d = (op_we_s || op_err_s) ? 32'd0 : mem_q[op_idx_s];
    end else begin
      rdata_d = rdata_q;
      err_d   = err_q;
    end
  end

  // The reset term blocks a write while reset is held with req_valid high.
  assign mem_wen_s = enter_resp_s && op_we_s && !op_err_s && reset;

  // State and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Memory array; deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_wen_s) begin
      mem_q[op_idx_s] <= op_wdata_s;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance
// sharing stimulus, checked against a word-array reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        memWrite;
  logic        rsp_ready;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        rr0, rr1, rv0, rv1, er0, er1;
  logic [31:0] rd0, rd1;
  logic        req_ready_m, rsp_valid_m, err_m;
  logic [31:0] rdata_m;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [2][64];

  always #5 clk = ~clk;

  assign req_ready_m = sel ? rr1 : rr0;
  assign rsp_valid_m = sel ? rv1 : rv0;
  assign err_m       = sel ? er1 : er0;
  assign rdata_m     = sel ? rd1 : rd0;

  data_mem_responder #(.ADDR_BITS(6), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rr0),
    .memWrite(memWrite), .addr(addr), .wdata(wdata), .rsp_valid(rv0),
    .rsp_ready(rsp_ready & ~sel), .rdata(rd0), .err(er0)
  );

  data_mem_responder #(.ADDR_BITS(6), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rr1),
    .memWrite(memWrite), .addr(addr), .wdata(wdata), .rsp_valid(rv1),
    .rsp_ready(rsp_ready & sel), .rdata(rd1), .err(er1)
  );

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] xr;
    bit          xe;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: 64-word array, error on misaligned or any address bit above 7.
  function automatic void model(input int i, input bit we, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] r, output bit e);
    e = (a[1:0] != 2'b00) || (a[31:8] != 24'd0);
    r = 32'd0;
    if (!e) begin
      if (we) mem_m[i][a[7:2]] = d;
      else    r = mem_m[i][a[7:2]];
    end
  endfunction

  // Issue one request on the selected instance, scramble inputs after
  // acceptance, optionally stall the response, then release it.
  task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] d,
                     input int stall, output logic [31:0] rd, output logic e);
    int          lat;
    logic [31:0] r0;
    logic        e0;
    chk("req_ready_idle", {31'd0, req_ready_m}, 32'd1);
    req_valid = 1'b1; memWrite = we; addr = a; wdata = d; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; memWrite = ~we; addr = $urandom; wdata = $urandom;
    chk("req_ready_busy", {31'd0, req_ready_m}, 32'd0);
    lat = 0;
    while (!rsp_valid_m && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, sel ? 32'd0 : 32'd2);
    r0 = rdata_m; e0 = err_m;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, rsp_valid_m}, 32'd1);
      chk("hold_rdata", rdata_m, r0);
      chk("hold_err", {31'd0, err_m}, {31'd0, e0});
      chk("hold_ready", {31'd0, req_ready_m}, 32'd0);
    end
    rd = r0; e = e0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("back_idle_ready", {31'd0, req_ready_m}, 32'd1);
    chk("back_idle_valid", {31'd0, rsp_valid_m}, 32'd0);
  endtask

  task automatic op(input string nm, input bit we, input logic [31:0] a,
                    input logic [31:0] d, input int stall);
    logic [31:0] xr, rd;
    bit          xe;
    logic        e;
    model(sel ? 1 : 0, we, a, d, xr, xe);
    txn(we, a, d, stall, rd, e);
    chk({nm, "_rdata"}, rd, xr);
    chk({nm, "_err"}, {31'd0, e}, {31'd0, xe});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, xr, a;
    logic        e;
    bit          xe;
    int          kind;

    reset = 1'b0; sel = 1'b0; req_valid = 1'b0; memWrite = 1'b0;
    rsp_ready = 1'b0; addr = 32'd0; wdata = 32'd0;

    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[3]  = '{1'b1, 32'h0000_0102, 32'h0000_0055, 32'h0000_0000, 1'b1};
    tbl[4]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA500_0000, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 1'b1};
    tbl[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA500_0000, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 32'hA500_003F, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    tbl[9]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    tbl[10] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[11] = '{1'b1, 32'h0000_0003, 32'h0000_0001, 32'h0000_0000, 1'b1};
    tbl[12] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA500_0000, 1'b0};

    // Reset state, visible while reset is still held.
    #12;
    chk("rst_req_ready_w2", {31'd0, rr0}, 32'd1);
    chk("rst_req_ready_w0", {31'd0, rr1}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rv0 | rv1}, 32'd0);
    chk("rst_err", {31'd0, er0 | er1}, 32'd0);
    chk("rst_rdata", rd0 | rd1, 32'd0);
    @(negedge clk); reset = 1'b1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 64; i++)
        op("init", 1'b1, 32'(i * 4), (s == 0 ? 32'hA500_0000 : 32'h5A00_0000) | 32'(i), 0);
    end

    sel = 1'b0;
    for (int i = 0; i < 13; i++) begin
      model(0, tbl[i].we, tbl[i].a, tbl[i].d, xr, xe);
      txn(tbl[i].we, tbl[i].a, tbl[i].d, 0, rd, e);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].xr);
      chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].xe});
    end

    op("backpressure", 1'b0, 32'h0000_0010, 32'd0, 5);

    sel = 1'b1;
    op("w0_store", 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 0);
    op("w0_load", 1'b0, 32'h0000_0044, 32'd0, 1);
    op("w0_oor", 1'b1, 32'h0001_0000, 32'h7777_7777, 0);
    op("w0_misal", 1'b0, 32'h0000_0045, 32'd0, 0);

    // Abort a store during WAIT with an asynchronous reset.
    sel = 1'b0;
    op("pre_load", 1'b0, 32'h0000_0024, 32'd0, 0);
    req_valid = 1'b1; memWrite = 1'b1; addr = 32'h0000_0020; wdata = 32'h1111_2222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_wait", {31'd0, req_ready_m}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("abort_rsp_valid", {31'd0, rv0}, 32'd0);
    chk("abort_req_ready", {31'd0, rr0}, 32'd1);
    chk("abort_rdata", rd0, 32'd0);
    chk("abort_err", {31'd0, er0}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    op("after_abort", 1'b0, 32'h0000_0020, 32'd0, 0);

    for (int n = 0; n < 150; n++) begin
      sel  = $urandom_range(0, 1) == 1;
      kind = $urandom_range(0, 7);
      if (kind <= 5)      a = {24'd0, 6'($urandom), 2'b00};
      else if (kind == 6) a = {24'd0, 6'($urandom), 2'($urandom_range(1, 3))};
      else                a = $urandom;
      op("rand", $urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
